// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: a shared prescaler tick drives per-channel
// off/on/blink/PWM engines, each reconfigured through a single-cycle write port.
module led_pattern_gen #(
  parameter int         CHANNELS   = 8,
  parameter int         TICK_DIV   = 50000,
  parameter int         PER_W      = 16,
  parameter logic [1:0] DEF_MODE   = 2'b10,
  parameter int         DEF_PERIOD = 1000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [4:0]          cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PER_W-1:0]    cfg_period,
  input  logic [PER_W-1:0]    cfg_duty,
  input  logic                sync_all,
  output logic                tick,
  output logic [CHANNELS-1:0] LEDG
);

  localparam int             PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_PWM   = 2'b11;

  logic [PS_W-1:0] presc_reg;

  assign tick = (presc_reg == PS_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      presc_reg <= '0;
    end else if (sync_all || tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + PS_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [1:0]       mode_reg;
      logic [PER_W-1:0] period_reg;
      logic [PER_W-1:0] duty_reg;
      logic [PER_W-1:0] cnt_reg;
      logic             state_reg;
      logic             led_reg;
      logic             sel;
      logic             led_next;
      logic [PER_W-1:0] last_cnt;
      logic             at_last;

      // Out-of-range channel indices never match any instance, so such writes vanish.
      assign sel      = cfg_we && (cfg_ch == 5'(gi));
      // A zero period behaves like a period of one.
      assign last_cnt = (period_reg == '0) ? '0 : period_reg - PER_W'(1);
      assign at_last  = (cnt_reg == last_cnt);

      always_comb begin
        led_next = 1'b0;
        case (mode_reg)
          MODE_OFF:   led_next = 1'b0;
          MODE_ON:    led_next = 1'b1;
          MODE_BLINK: led_next = state_reg;
          MODE_PWM:   led_next = (cnt_reg < duty_reg);
          default:    led_next = 1'b0;
        endcase
      end

      // Priority: reset, then a write, then sync_all; a tick only advances untouched channels.
      always_ff @(posedge CLOCK_50) begin
        if (reset) begin
          mode_reg   <= DEF_MODE;
          period_reg <= PER_W'(DEF_PERIOD);
          duty_reg   <= '0;
          cnt_reg    <= '0;
          state_reg  <= 1'b0;
          led_reg    <= 1'b0;
        end else begin
          led_reg <= led_next;
          if (sel) begin
            mode_reg   <= cfg_mode;
            period_reg <= cfg_period;
            duty_reg   <= cfg_duty;
            cnt_reg    <= '0;
            state_reg  <= 1'b0;
          end else if (sync_all) begin
            cnt_reg   <= '0;
            state_reg <= 1'b0;
          end else if (tick) begin
            case (mode_reg)
              MODE_BLINK: begin
                if (at_last) begin
                  cnt_reg   <= '0;
                  state_reg <= ~state_reg;
                end else begin
                  cnt_reg <= cnt_reg + PER_W'(1);
                end
              end
              MODE_PWM: cnt_reg <= at_last ? '0 : cnt_reg + PER_W'(1);
              default:  cnt_reg <= '0;
            endcase
          end
        end
      end

      assign LEDG[gi] = led_reg;
    end
  endgenerate

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: stimulus queues hand-computed LEDG/tick
// values keyed by cycle; a negedge monitor pops and compares them.
module tb_led_pattern_gen;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_we;
  logic [4:0]    cfg_ch;
  logic [1:0]    cfg_mode;
  logic [15:0]   cfg_period;
  logic [15:0]   cfg_duty;
  logic          sync_all;
  logic          tick;
  logic [CH-1:0] LEDG;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .CHANNELS(CH), .TICK_DIV(4), .PER_W(16), .DEF_MODE(2'b10), .DEF_PERIOD(3)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
    .sync_all(sync_all), .tick(tick), .LEDG(LEDG)
  );

  // cyc == N while sampling at the negedge that follows rising edge N
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            at;
    bit            is_tick;
    logic [CH-1:0] mask;
    logic [CH-1:0] val;
    string         name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic expect_led(input int c, input logic [CH-1:0] m, input logic [CH-1:0] v,
                            input string nm);
    exp_t e;
    e.at = c; e.is_tick = 1'b0; e.mask = m; e.val = v; e.name = nm;
    q.push_back(e);
  endtask

  task automatic expect_tick(input int c, input logic v, input string nm);
    exp_t e;
    e.at = c; e.is_tick = 1'b1; e.mask = '0; e.val = {{(CH-1){1'b0}}, v}; e.name = nm;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].at <= cyc) begin
        n_checks++;
        if (q[i].at < cyc) begin
          $display("FAIL %s: cycle %0d went unchecked (now %0d)", q[i].name, q[i].at, cyc);
        end else if (q[i].is_tick) begin
          if (tick === q[i].val[0]) begin
            n_pass++;
            $display("cyc %0d %s: tick=%0b ok", cyc, q[i].name, tick);
          end else begin
            $display("FAIL %s: cycle %0d tick=%0b required %0b", q[i].name, cyc, tick, q[i].val[0]);
          end
        end else begin
          if ((LEDG & q[i].mask) === q[i].val) begin
            n_pass++;
            $display("cyc %0d %s: LEDG&%b=%b ok", cyc, q[i].name, q[i].mask, LEDG & q[i].mask);
          end else begin
            $display("FAIL %s: cycle %0d LEDG&%b=%b required %b", q[i].name, cyc, q[i].mask,
                     LEDG & q[i].mask, q[i].val);
          end
        end
        q.delete(i);
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Issues a write that takes effect on rising edge w.
  task automatic cfg_write(input int w, input logic [4:0] ch, input logic [1:0] mode,
                           input logic [15:0] per, input logic [15:0] duty, input bit sync);
    wait_until(w - 1);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_period = per; cfg_duty = duty;
    sync_all = sync;
    @(negedge clk);
    cfg_we = 1'b0; sync_all = 1'b0;
  endtask

  initial begin
    int r;
    int s;
    int r2;
    reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0;
    cfg_period = '0; cfg_duty = '0; sync_all = 1'b0;

    // Reset release: edge r is the last reset edge; ticks applied on edges r+4k.
    wait_until(2);
    r = 3;
    expect_led(r, 4'hF, 4'h0, "rst_led");
    expect_tick(r, 1'b0, "rst_tick");
    expect_tick(r + 2, 1'b0, "tick_lo_2");
    expect_tick(r + 3, 1'b1, "tick_hi_3");
    expect_tick(r + 4, 1'b0, "tick_lo_4");
    expect_tick(r + 7, 1'b1, "tick_hi_7");
    expect_led(r + 12, 4'hF, 4'h0, "pre_rise");
    expect_led(r + 13, 4'hF, 4'hF, "first_rise");
    expect_led(r + 24, 4'hF, 4'hF, "pre_fall");
    expect_led(r + 25, 4'hF, 4'h0, "first_fall");
    wait_until(r);
    reset = 1'b0;
    wait_until(r + 25);

    // ch1 forced on then off; other channels keep blinking.
    expect_led(r + 28, 4'b0010, 4'b0000, "ch1_before_on");
    expect_led(r + 29, 4'hF, 4'b0010, "ch1_on");
    expect_led(r + 32, 4'hF, 4'b0010, "ch1_still_on");
    expect_led(r + 33, 4'hF, 4'b0000, "ch1_off");
    expect_led(r + 36, 4'hF, 4'b0000, "others_lo");
    expect_led(r + 37, 4'hF, 4'b1101, "others_hi");
    cfg_write(r + 28, 5'd1, 2'b01, 16'd3, 16'd0, 1'b0);
    cfg_write(r + 32, 5'd1, 2'b00, 16'd3, 16'd0, 1'b0);
    wait_until(r + 37);

    // ch2 PWM period 4, duty 1: high 4 cycles, low 12.
    expect_led(r + 42, 4'b0100, 4'b0100, "pwm_d1_hi_a");
    expect_led(r + 44, 4'b0100, 4'b0100, "pwm_d1_hi_b");
    expect_led(r + 45, 4'b0100, 4'b0000, "pwm_d1_lo_a");
    expect_led(r + 56, 4'b0100, 4'b0000, "pwm_d1_lo_b");
    expect_led(r + 57, 4'b0100, 4'b0100, "pwm_d1_hi_c");
    expect_led(r + 60, 4'b0100, 4'b0100, "pwm_d1_hi_d");
    expect_led(r + 61, 4'b0100, 4'b0000, "pwm_d1_lo_c");
    cfg_write(r + 41, 5'd2, 2'b11, 16'd4, 16'd1, 1'b0);
    wait_until(r + 61);

    expect_led(r + 63, 4'b0100, 4'b0000, "pwm_d0_a");
    expect_led(r + 70, 4'b0100, 4'b0000, "pwm_d0_b");
    expect_led(r + 80, 4'b0100, 4'b0000, "pwm_d0_c");
    cfg_write(r + 62, 5'd2, 2'b11, 16'd4, 16'd0, 1'b0);
    wait_until(r + 80);

    expect_led(r + 83, 4'b0100, 4'b0100, "pwm_d9_a");
    expect_led(r + 90, 4'b0100, 4'b0100, "pwm_d9_b");
    expect_led(r + 100, 4'b0100, 4'b0100, "pwm_d9_c");
    cfg_write(r + 82, 5'd2, 2'b11, 16'd4, 16'd9, 1'b0);
    wait_until(r + 100);

    // ch0 blink with period 0 toggles on every tick; then an out-of-range write.
    expect_led(r + 103, 4'b0001, 4'b0000, "p0_clr");
    expect_led(r + 104, 4'b0001, 4'b0000, "p0_lo");
    expect_led(r + 105, 4'b0001, 4'b0001, "p0_hi_a");
    expect_led(r + 108, 4'b0001, 4'b0001, "p0_hi_b");
    expect_led(r + 109, 4'b0001, 4'b0000, "p0_lo_b");
    expect_led(r + 113, 4'b0001, 4'b0001, "p0_hi_c");
    expect_led(r + 116, 4'b1010, 4'b1000, "oor_a");
    expect_led(r + 121, 4'hF, 4'b0101, "oor_b");
    cfg_write(r + 102, 5'd0, 2'b10, 16'd0, 16'd0, 1'b0);
    cfg_write(r + 114, 5'd7, 2'b01, 16'd1, 16'd0, 1'b0);
    wait_until(r + 121);

    // Write ch3 together with sync_all on a tick edge.
    s = r + 124;
    expect_tick(s - 1, 1'b1, "tick_at_sync");
    expect_led(s, 4'hF, 4'b0101, "pre_sync");
    expect_tick(s, 1'b0, "sync_tick_lo");
    expect_led(s + 1, 4'hF, 4'b1100, "sync_a");
    expect_tick(s + 3, 1'b1, "sync_tick_hi");
    expect_led(s + 4, 4'hF, 4'b1100, "sync_b");
    expect_led(s + 5, 4'hF, 4'b0101, "sync_c");
    expect_led(s + 9, 4'hF, 4'b1100, "sync_d");
    cfg_write(s, 5'd3, 2'b11, 16'd2, 16'd1, 1'b1);
    wait_until(s + 9);

    // One-cycle reset mid-PWM returns everything to default blink.
    r2 = s + 11;
    expect_led(r2, 4'hF, 4'h0, "mid_rst_led");
    expect_tick(r2, 1'b0, "mid_rst_tick");
    expect_tick(r2 + 3, 1'b1, "mid_rst_tick_hi");
    expect_led(r2 + 12, 4'hF, 4'h0, "def_pre_rise");
    expect_led(r2 + 13, 4'hF, 4'hF, "def_rise");
    wait_until(r2 - 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_until(r2 + 13);

    for (int k = 0; k < 50 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      $display("FAIL drain: %0d checks pending, required 0", q.size());
      n_checks += q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Multi-channel LED driver for the board's green LED bank. It is the parametrised successor to the single fixed-rate blinker. A shared prescaler produces a time-base tick. Each channel is independently configured at run time as off, on, blink (programmable half-period) or PWM (programmable period and duty). Configuration arrives through a single-cycle write port from a controller or switch-decoder block.

Parameters:
CHANNELS, 8, number of LED channels (1..32)
TICK_DIV, 50000, CLOCK_50 cycles per time-base tick (1 ms at 50 MHz); must be >= 2
PER_W, 16, width of per-channel period/duty registers
DEF_MODE, 2'b10, mode loaded into every channel at reset (blink)
DEF_PERIOD, 1000, period loaded into every channel at reset (1 s half-period)

Ports:
CLOCK_50  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
cfg_we  input  1  config write strobe; one write per cycle it is high
cfg_ch  input  5  target channel index
cfg_mode  input  2  00 off, 01 on, 10 blink, 11 PWM
cfg_period  input  PER_W  blink: half-period in ticks; PWM: full period in ticks
cfg_duty  input  PER_W  PWM high time in ticks; ignored in other modes
sync_all  input  1  restarts all channel counters and the prescaler
tick  output  1  one-cycle time-base pulse (debug/heartbeat)
LEDG  output  CHANNELS  LED drive, registered, 1 = lit

Behaviour:
- Reset (sampled on CLOCK_50 edge while reset=1) has priority over everything else. Prescaler=0, tick=0, LEDG=0. Every channel: mode=DEF_MODE, period=DEF_PERIOD, duty=0, cnt=0, blink state=0.
- Prescaler counts 0..TICK_DIV-1 and wraps. tick=1 for exactly the cycle in which prescaler==TICK_DIV-1. Channel counters advance only on edges where tick=1.
- Effective period: cfg_period=0 is treated as 1. Counter widths are PER_W; no overflow is possible because cnt wraps at period-1.
- Blink mode, per tick:
  - if cnt==period-1: cnt<=0 and state toggles;
  - else cnt<=cnt+1.
  - LED value = state.
- PWM mode, per tick:
  - cnt wraps 0..period-1.
  - LED value = (cnt < duty). duty=0 means always off; duty>=period means always on.
- Off/on modes: LED value constant 0/1; cnt is held at 0.
- LEDG[i] is registered: it equals the channel's computed value from the previous cycle. Latency is 1 cycle from a state or config change to the pin.
- Config write (cfg_we=1 at an edge, cfg_ch<CHANNELS):
  - mode, period and duty of that channel are loaded;
  - its cnt and state are cleared to 0 on the same edge;
  - other channels are unaffected.
  - cfg_ch>=CHANNELS: the write is silently ignored.
  - Back-to-back writes to the same channel: last write wins, and the counter is re-cleared each time.
- Write coinciding with a tick for the same channel: the write wins (cnt=0, state=0); that tick is not applied.
- sync_all=1 at an edge:
  - prescaler=0 and all cnt/state are cleared; configs are kept.
  - Combined with cfg_we: the config is loaded and all counters are cleared.
  - sync_all overrides a tick in the same cycle.
- Reset asserted mid-pattern: outputs and configs return to reset values on that edge, regardless of cfg_we or sync_all.

Test Plan:
- TICK_DIV=4, CHANNELS=4, DEF_PERIOD=3; release reset -> tick pulses every 4 cycles. LEDG[3:0] first rise 0xF one cycle after the 3rd tick, then toggles every 12 cycles.
- Write ch1 mode=01 -> LEDG[1]=1 one cycle after the write edge. Write ch1 mode=00 -> LEDG[1]=0 one cycle later. Other bits keep blinking undisturbed.
- Write ch2 mode=11, period=4, duty=1 -> LEDG[2] high 4 cycles, low 12 cycles, repeating. Repeat with duty=0 (never high) and duty=9 (never low).
- Write ch0 blink with period=0 -> LEDG[0] toggles every tick (every 4 cycles). Write cfg_ch=7 (out of range) -> no channel changes.
- Drive cfg_we for ch3 and sync_all on the same edge as a tick -> ch3 has the new config with cnt=0. All channels are restarted in phase; the tick is not applied to any counter.
- Assert reset for 1 cycle mid-PWM -> next cycle LEDG=0 and tick=0; all channels revert to DEF_MODE/DEF_PERIOD blink.
